// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and widths for the convolution result collector
package conv_pkg;
  localparam int DATA_W = 64;
  localparam int ROW_BEATS_W = 24;
  localparam int TOTAL_BEATS_W = 36;
  typedef enum logic [2:0] {IDLE, LOAD, COLLECT, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_result_collect_if.sv
// conv_result_collect_if: result input stream plus DMA output stream
interface conv_result_collect_if #(parameter int DATA_W = conv_pkg::DATA_W);
  logic S_Valid;
  logic [DATA_W-1:0] S_Data;
  logic S_ready;
  logic M_Valid;
  logic [DATA_W-1:0] M_Data;
  logic M_Last;
  logic M_Ready;
  modport slave (input S_Valid, S_Data, M_Ready, output S_ready, M_Valid, M_Data, M_Last);
  modport master (output S_Valid, S_Data, M_Ready, input S_ready, M_Valid, M_Data, M_Last);
endinterface

// File: rtl/result_fifo.sv
// result_fifo: synchronous first-word-fall-through buffer with exact occupancy count
module result_fifo
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign full = count[AW];
  assign empty = count == '0;
  // a write into a full buffer is dropped, a read from an empty one is ignored
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;
endmodule

// File: rtl/conv_result_collect.sv
// conv_result_collect: buffers one layer of result beats and streams it to DMA; RESULT_RELU_EN clamps negative lanes to 0
module conv_result_collect
  import conv_pkg::*;
#(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int FIFO_AW = 9,
  parameter int WIDTH_FEATURE_SIZE = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start_Wb,
  input  logic [WIDTH_FEATURE_SIZE-1:0] ROW_NUM_CHANNEL_OUT_REG,
  input  logic [WIDTH_FEATURE_SIZE-1:0] COMPUTE_TIMES_CHANNEL_OUT_REG,
  conv_result_collect_if.slave          bus,
  output logic                          Write_Complete,
  output logic                          Overflow_Err
);
  localparam int DEPTH = 1 << FIFO_AW;
  state_t state, state_nx;
  logic [ROW_BEATS_W-1:0] row_beats, row_beats_c, beat_rx;
  logic [TOTAL_BEATS_W-1:0] total_beats, total_c, beat_tx;
  logic [WIDTH_FEATURE_SIZE-1:0] row_num, rows_rx;
  logic [FIFO_AW:0] count, free;
  logic [DATA_W-1:0] wdata;
  logic full, empty, wr_en, rd_en, last_acc, row_end;
  assign row_beats_c = ROW_BEATS_W'(ROW_NUM_CHANNEL_OUT_REG) * ROW_BEATS_W'(COMPUTE_TIMES_CHANNEL_OUT_REG);
  assign total_c = TOTAL_BEATS_W'(row_beats_c) * TOTAL_BEATS_W'(ROW_NUM_CHANNEL_OUT_REG);
  assign free = (FIFO_AW+1)'(DEPTH) - count;
  assign wr_en = bus.S_Valid && state == COLLECT;
  assign row_end = beat_rx == row_beats - ROW_BEATS_W'(1);
  assign bus.M_Valid = (state == COLLECT || state == DRAIN) && !empty;
  assign bus.M_Last = bus.M_Valid && beat_tx == total_beats - TOTAL_BEATS_W'(1);
  assign rd_en = bus.M_Valid && bus.M_Ready;
  assign last_acc = rd_en && bus.M_Last;
  // room for the requested row plus the one still in the compute pipeline
  assign bus.S_ready = state == COLLECT && rows_rx < row_num &&
                       (ROW_BEATS_W+1)'(free) >= {row_beats, 1'b0};
  assign Write_Complete = state == DONE;
  always_comb begin
    wdata = bus.S_Data;
`ifdef RESULT_RELU_EN
    for (int i = 0; i < DATA_W/8; i++) if (bus.S_Data[8*i+7]) wdata[8*i+:8] = '0;
`endif
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = Start_Wb ? LOAD : IDLE;
      LOAD:    state_nx = total_c == '0 ? DONE : COLLECT;
      COLLECT: state_nx = last_acc ? DONE : rows_rx == row_num ? DRAIN : COLLECT;
      DRAIN:   state_nx = last_acc ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      row_beats <= '0;
      total_beats <= '0;
      row_num <= '0;
      beat_rx <= '0;
      rows_rx <= '0;
      beat_tx <= '0;
      Overflow_Err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        row_beats <= row_beats_c;
        total_beats <= total_c;
        row_num <= ROW_NUM_CHANNEL_OUT_REG;
        beat_rx <= '0;
        rows_rx <= '0;
        beat_tx <= '0;
      end else begin
        if (wr_en) beat_rx <= row_end ? '0 : beat_rx + ROW_BEATS_W'(1);
        if (wr_en && row_end) rows_rx <= rows_rx + WIDTH_FEATURE_SIZE'(1);
        if (rd_en) beat_tx <= beat_tx + TOTAL_BEATS_W'(1);
      end
      if (bus.S_Valid && (state != COLLECT || full)) Overflow_Err <= 1'b1;
      else if (Start_Wb && state == IDLE) Overflow_Err <= 1'b0;
    end
  result_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(state == LOAD),
    .wr_en(wr_en),
    .wr_data(wdata),
    .rd_en(rd_en),
    .rd_data(bus.M_Data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_conv_result_collect.sv
// tb_conv_result_collect: table-driven layers plus corner sequences, scoreboard-checked output stream
module tb_conv_result_collect;
  typedef struct {int row; int ch; int mode; int exp_total;} vec_t;
  logic clk = 0, rst = 0, Start_Wb = 0;
  logic [11:0] row_reg = 0, ch_reg = 0;
  logic Write_Complete, Overflow_Err;
  conv_result_collect_if #(.DATA_W(64)) bus();
  conv_result_collect dut (
    .clk(clk),
    .rst(rst),
    .Start_Wb(Start_Wb),
    .ROW_NUM_CHANNEL_OUT_REG(row_reg),
    .COMPUTE_TIMES_CHANNEL_OUT_REG(ch_reg),
    .bus(bus),
    .Write_Complete(Write_Complete),
    .Overflow_Err(Overflow_Err)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [63:0] q[$];
  int out_idx, beat_cnt, wc_cnt, exp_total, ready_mode = 0;
  bit held, saw_valid, watch_idle, fixed_en;
  logic [63:0] hold_d, fixed_d, fixed_exp;
  logic hold_l;
  vec_t vecs[6];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] relu(input logic [63:0] d);
    logic [63:0] r;
    r = d;
`ifdef RESULT_RELU_EN
    for (int i = 0; i < 8; i++) if (d[8*i+7]) r[8*i+:8] = 8'h00;
`endif
    return r;
  endfunction
  initial begin
    bus.M_Ready = 1;
    forever begin
      @(posedge clk);
      #1;
      bus.M_Ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~bus.M_Ready :
                    ready_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) held = 0;
    if (watch_idle && bus.M_Valid) saw_valid = 1;
    if (Write_Complete) wc_cnt++;
    if (bus.M_Valid) begin
      if (held) begin
        check("hold_data", bus.M_Data, hold_d);
        check("hold_last", bus.M_Last, hold_l);
      end
      if (bus.M_Ready) begin
        if (q.size() == 0) check("unexpected_beat", bus.M_Valid, 0);
        else begin
          check("data", bus.M_Data, q.pop_front());
          check("last", bus.M_Last, out_idx == exp_total - 1);
        end
        out_idx++;
        beat_cnt++;
        held = 0;
      end else begin
        held = 1;
        hold_d = bus.M_Data;
        hold_l = bus.M_Last;
      end
    end else held = 0;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic send_beat(input logic [63:0] d, input logic [63:0] e, input bit track);
    @(posedge clk);
    #1;
    bus.S_Valid = 1;
    bus.S_Data = d;
    if (track) q.push_back(e);
  endtask
  task automatic idle_s();
    @(posedge clk);
    #1;
    bus.S_Valid = 0;
  endtask
  task automatic wait_sready(input string name);
    int t = 0;
    @(negedge clk);
    while (!bus.S_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(name, bus.S_ready, 1);
  endtask
  task automatic start(input int row, input int ch);
    @(posedge clk);
    #1;
    row_reg = 12'(row);
    ch_reg = 12'(ch);
    Start_Wb = 1;
    out_idx = 0;
    beat_cnt = 0;
    wc_cnt = 0;
    exp_total = row * ch * row;
    @(posedge clk);
    #1;
    Start_Wb = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.S_Valid = 0;
    rst = 0;
    @(posedge clk);
    #1;
    q.delete();
    rst = 1;
  endtask
  task automatic run_layer(input vec_t v);
    logic [63:0] d;
    int t = 0;
    ready_mode = v.mode;
    start(v.row, v.ch);
    if (v.row * v.ch > 0) begin
      for (int r = 0; r < v.row; r++) begin
        wait_sready("sready_row");
        for (int b = 0; b < v.row * v.ch; b++) begin
          d = fixed_en ? fixed_d : {$urandom, $urandom};
          send_beat(d, fixed_en ? fixed_exp : relu(d), 1);
        end
        idle_s();
      end
    end
    while (wc_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("wc_pulses", wc_cnt, 1);
    check("beats_out", beat_cnt, v.exp_total);
    check("queue_empty", q.size(), 0);
    check("overflow_clear", Overflow_Err, 0);
  endtask
  initial begin
    int t;
    logic [63:0] d;
    bus.S_Valid = 0;
    bus.S_Data = 0;
    vecs[0] = '{4, 2, 0, 32};
    vecs[1] = '{2, 16, 1, 64};
    vecs[2] = '{3, 3, 3, 27};
    vecs[3] = '{0, 5, 0, 0};
    vecs[4] = '{5, 0, 0, 0};
    vecs[5] = '{1, 1, 1, 1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", bus.S_ready, 0);
    check("rst_mvalid", bus.M_Valid, 0);
    check("rst_mlast", bus.M_Last, 0);
    check("rst_wc", Write_Complete, 0);
    check("rst_ovf", Overflow_Err, 0);
    rst = 1;
    foreach (vecs[i]) run_layer(vecs[i]);
    fixed_en = 1;
    fixed_d = 64'h807FFF01008110F0;
`ifdef RESULT_RELU_EN
    fixed_exp = 64'h007F000100001000;
`else
    fixed_exp = 64'h807FFF01008110F0;
`endif
    run_layer('{1, 1, 0, 1});
    fixed_en = 0;
    send_beat(64'h1, 64'h0, 0);
    idle_s();
    @(negedge clk);
    check("ovf_idle_beat", Overflow_Err, 1);
    repeat (3) @(negedge clk);
    check("ovf_sticky", Overflow_Err, 1);
    run_layer('{0, 5, 0, 0});
    ready_mode = 2;
    start(16, 16);
    wait_sready("sready_empty_fifo");
    for (int b = 0; b < 257; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, relu(d), 1);
    end
    idle_s();
    @(negedge clk);
    check("sready_after_257", bus.S_ready, 0);
    do_reset();
    ready_mode = 2;
    start(8, 9);
    wait_sready("sready_fill");
    for (int b = 0; b < 512; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, relu(d), 1);
    end
    idle_s();
    @(negedge clk);
    check("ovf_at_full", Overflow_Err, 0);
    send_beat(64'hDEADBEEFDEADBEEF, 64'h0, 0);
    idle_s();
    @(negedge clk);
    check("ovf_dropped", Overflow_Err, 1);
    ready_mode = 0;
    t = 0;
    while (q.size() > 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drained_512", q.size(), 0);
    check("dropped_not_output", bus.M_Valid, 0);
    check("ovf_kept", Overflow_Err, 1);
    do_reset();
    ready_mode = 0;
    start(4, 2);
    wait_sready("sready_mid_rst");
    for (int b = 0; b < 10; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, relu(d), 1);
    end
    @(posedge clk);
    #2;
    rst = 0;
    bus.S_Valid = 0;
    #1;
    check("mid_rst_mvalid", bus.M_Valid, 0);
    check("mid_rst_sready", bus.S_ready, 0);
    check("mid_rst_mlast", bus.M_Last, 0);
    check("mid_rst_wc", Write_Complete, 0);
    check("mid_rst_ovf", Overflow_Err, 0);
    q.delete();
    saw_valid = 0;
    watch_idle = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    repeat (20) @(negedge clk);
    check("no_valid_after_rst", saw_valid, 0);
    watch_idle = 0;
    run_layer('{4, 2, 1, 32});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
